// File: rtl/spi_flash_arb_pkg.sv
// Shared types and constants for the SPI flash read-engine arbiter.
package spi_flash_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam int PORT_IF   = 0;
  localparam int PORT_LD   = 1;
  localparam int NUM_PORTS = 2;

endpackage

// File: rtl/arb_port_cache.sv
// One-entry last-address cache for a single arbiter port: tag/data/valid,
// hit compare, fill write and invalidate.
module arb_port_cache
  import spi_flash_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              inval,
  input  logic              wr_en,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              hit,
  output logic [DATA_W-1:0] rd_data
);

  logic              valid_reg;
  logic [ADDR_W-1:0] tag_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else begin
      if (wr_en) begin
        tag_reg  <= wr_addr;
        data_reg <= wr_data;
      end
      // Invalidate wins over a same-cycle fill so a stale word never becomes valid.
      if (inval)
        valid_reg <= 1'b0;
      else if (wr_en)
        valid_reg <= wr_valid;
    end
  end

  assign hit     = req && valid_reg && (addr == tag_reg) && !inval;
  assign rd_data = data_reg;

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash read engine between the fetch and constant-load ports,
// with a per-port one-entry cache and fetch-priority arbitration bounded by a load starvation limit.
module spi_flash_arbiter
  import spi_flash_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_ready,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              inval,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_busy,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_data,
  output logic              grant_ld
);

  arb_state_t state_reg, state_next;

  logic [NUM_PORTS-1:0] req_vec, hit_vec, miss_vec, wr_en_vec;
  logic [NUM_PORTS-1:0] ready_reg;
  logic [ADDR_W-1:0]    addr_vec   [NUM_PORTS];
  logic [DATA_W-1:0]    cache_data [NUM_PORTS];
  logic [DATA_W-1:0]    data_reg   [NUM_PORTS];
  logic                 owner_reg, pend_inval_reg;
  logic [3:0]           streak_reg;
  logic                 grant, grant_sel, fill;

  assign req_vec            = {ld_req, if_req};
  assign addr_vec[PORT_IF]  = if_addr;
  assign addr_vec[PORT_LD]  = ld_addr;
  assign miss_vec           = req_vec & ~hit_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign wr_en_vec[gi] = fill && (int'(owner_reg) == gi);

      arb_port_cache #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
      ) u_cache (
        .clk      (clk),
        .rst      (rst),
        .req      (req_vec[gi]),
        .addr     (addr_vec[gi]),
        .inval    (inval),
        .wr_en    (wr_en_vec[gi]),
        .wr_valid (!pend_inval_reg),
        .wr_addr  (eng_addr),
        .wr_data  (eng_data),
        .hit      (hit_vec[gi]),
        .rd_data  (cache_data[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    grant_sel  = 1'b0;
    eng_start  = 1'b0;
    fill       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|miss_vec) begin
          grant = 1'b1;
          // Load wins only when it is the sole miss or has waited out the streak.
          if (!miss_vec[PORT_IF])
            grant_sel = 1'b1;
          else if (miss_vec[PORT_LD] && (streak_reg == 4'(STARVE_MAX)))
            grant_sel = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!eng_busy) begin
          eng_start  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (eng_done) begin
          fill       = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_reg      <= '0;
      owner_reg      <= 1'b0;
      pend_inval_reg <= 1'b0;
      streak_reg     <= '0;
      eng_addr       <= '0;
      for (int i = 0; i < NUM_PORTS; i++) data_reg[i] <= '0;
    end else begin
      ready_reg <= '0;
      if (state_reg == IDLE) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (hit_vec[i]) begin
            ready_reg[i] <= 1'b1;
            data_reg[i]  <= cache_data[i];
          end
        end
      end
      // The ready of the fill is registered, so it appears during RESP.
      if (fill && req_vec[owner_reg]) begin
        ready_reg[owner_reg] <= 1'b1;
        data_reg[owner_reg]  <= eng_data;
      end

      if (grant) begin
        owner_reg      <= grant_sel;
        eng_addr       <= addr_vec[grant_sel];
        pend_inval_reg <= inval;
      end else if (state_reg != IDLE) begin
        pend_inval_reg <= pend_inval_reg | inval;
      end

      if (state_reg == IDLE) begin
        if (!ld_req || (grant && grant_sel))
          streak_reg <= '0;
        else if (grant && (streak_reg < 4'(STARVE_MAX)))
          streak_reg <= streak_reg + 4'd1;
      end
    end
  end

  assign if_ready = ready_reg[PORT_IF];
  assign ld_ready = ready_reg[PORT_LD];
  assign if_data  = data_reg[PORT_IF];
  assign ld_data  = data_reg[PORT_LD];
  assign grant_ld = owner_reg;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench for spi_flash_arbiter with a behavioural flash engine.
module tb_spi_flash_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, ld_req = 1'b0, inval = 1'b0;
  logic [AW-1:0] if_addr = '0, ld_addr = '0;
  logic [DW-1:0] if_data, ld_data;
  logic          if_ready, ld_ready;
  logic          eng_start, eng_busy, eng_done, grant_ld;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_data;

  spi_flash_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .inval(inval),
    .eng_start(eng_start), .eng_addr(eng_addr), .eng_busy(eng_busy),
    .eng_done(eng_done), .eng_data(eng_data), .grant_ld(grant_ld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [DW-1:0] if_q[$], ld_q[$];
  logic [AW:0]   eng_q[$];
  int if_rdy_cyc = 0, ld_rdy_cyc = 0, start_cyc = 0, done_cyc = 0, n_starts = 0;
  int eng_lat = 40;
  logic [DW-1:0] exp_d;
  logic [AW:0]   exp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a ready or an engine launch.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_ready) begin
        if_rdy_cyc = cyc;
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_spurious_ready actual=%h required=none", if_data);
        end else begin
          exp_d = if_q.pop_front();
          chk("if_data", 32'(if_data), 32'(exp_d));
          $display("txn fetch ready data=%h cyc=%0d", if_data, cyc);
        end
      end
      if (ld_ready) begin
        ld_rdy_cyc = cyc;
        if (ld_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ld_spurious_ready actual=%h required=none", ld_data);
        end else begin
          exp_d = ld_q.pop_front();
          chk("ld_data", 32'(ld_data), 32'(exp_d));
          $display("txn load ready data=%h cyc=%0d", ld_data, cyc);
        end
      end
      if (eng_start) begin
        n_starts++;
        start_cyc = cyc;
        if (eng_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL eng_spurious_start actual=%h required=none", eng_addr);
        end else begin
          exp_e = eng_q.pop_front();
          chk("eng_grant_addr", 32'({grant_ld, eng_addr}), 32'(exp_e));
          $display("txn eng_start addr=%h grant_ld=%0d cyc=%0d", eng_addr, grant_ld, cyc);
        end
      end
    end
  end

  // Flash engine model: word = addr ^ 0xA5B5, done eng_lat cycles after launch.
  initial begin
    bit active;
    int cnt;
    logic [AW-1:0] cap;
    active = 0; cnt = 0; cap = '0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; eng_busy = 1'b0; eng_done = 1'b0;
      end else begin
        if (eng_done) begin
          eng_done = 1'b0;
          eng_busy = 1'b0;
        end
        if (active) begin
          eng_busy = 1'b1;
          cnt--;
          if (cnt == 0) begin
            eng_done = 1'b1;
            eng_data = cap ^ 16'hA5B5;
            done_cyc = cyc;
            active   = 0;
          end
        end else if (eng_start) begin
          active = 1;
          cnt    = eng_lat;
          cap    = eng_addr;
        end
      end
    end
  end

  task automatic wait_ready(input int port, output int rc);
    bit seen;
    seen = 0; rc = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if ((port == 0) ? if_ready : ld_ready) begin
        seen = 1; rc = cyc;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ready_timeout port=%0d actual=no_ready required=ready", port);
    end
  endtask

  task automatic wait_start();
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (eng_start) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL start_timeout actual=no_start required=eng_start");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_ready"}, 32'(if_ready), 0);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 0);
    chk({tag, "_if_data"}, 32'(if_data), 0);
    chk({tag, "_ld_data"}, 32'(ld_data), 0);
    chk({tag, "_eng_start"}, 32'(eng_start), 0);
    chk({tag, "_eng_addr"}, 32'(eng_addr), 0);
    chk({tag, "_grant_ld"}, 32'(grant_ld), 0);
  endtask

  initial begin
    int rc, r1, r2, s0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Cold fetch 0x0010, 40-cycle engine.
    eng_lat = 40;
    if_q.push_back(16'hA5A5);
    eng_q.push_back({1'b0, 16'h0010});
    s0 = n_starts;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010; rc = cyc;
    wait_ready(0, r1);
    if_req = 1'b0;
    chk("cold_start_cyc", 32'(start_cyc), 32'(rc + 1));
    chk("cold_ready_cyc", 32'(r1), 32'(done_cyc + 1));
    chk("cold_start_count", 32'(n_starts), 32'(s0 + 1));

    // Repeat fetch hits.
    if_q.push_back(16'hA5A5);
    s0 = n_starts;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010; rc = cyc;
    wait_ready(0, r1);
    if_req = 1'b0;
    chk("hit_ready_cyc", 32'(r1), 32'(rc + 1));
    chk("hit_no_start", 32'(n_starts), 32'(s0));

    // Fetch hit and load miss in the same cycle.
    eng_lat = 5;
    if_q.push_back(16'hA5A5);
    ld_q.push_back(16'hA6B5);
    eng_q.push_back({1'b1, 16'h0300});
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010;
    ld_req = 1'b1; ld_addr = 16'h0300; rc = cyc;
    fork
      begin wait_ready(0, r1); if_req = 1'b0; end
      begin wait_ready(1, r2); ld_req = 1'b0; end
    join
    chk("mix_if_ready_cyc", 32'(r1), 32'(rc + 1));
    chk("mix_start_cyc", 32'(start_cyc), 32'(rc + 1));
    chk("mix_ld_ready_cyc", 32'(r2), 32'(done_cyc + 1));

    // Both miss continuously: four fetch grants then one load grant.
    eng_lat = 3;
    eng_q.push_back({1'b0, 16'h0100});
    eng_q.push_back({1'b0, 16'h0101});
    eng_q.push_back({1'b0, 16'h0102});
    eng_q.push_back({1'b0, 16'h0103});
    eng_q.push_back({1'b1, 16'h0200});
    eng_q.push_back({1'b0, 16'h0104});
    if_q.push_back(16'hA4B5);
    if_q.push_back(16'hA4B4);
    if_q.push_back(16'hA4B7);
    if_q.push_back(16'hA4B6);
    if_q.push_back(16'hA4B1);
    ld_q.push_back(16'hA7B5);
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 16'h0200;
    if_req = 1'b1; if_addr = 16'h0100;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          int rk;
          wait_ready(0, rk);
          if (k < 4) if_addr = 16'h0100 + 16'(k + 1);
          else       if_req  = 1'b0;
        end
      end
      begin wait_ready(1, r2); ld_req = 1'b0; end
    join

    // Invalidate during WAIT: word still delivered, next read misses.
    eng_lat = 10;
    ld_q.push_back(16'hA5F5);
    eng_q.push_back({1'b1, 16'h0040});
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 16'h0040;
    wait_start();
    repeat (3) @(negedge clk);
    inval = 1'b1;
    @(negedge clk);
    inval = 1'b0;
    wait_ready(1, r2);
    ld_req = 1'b0;
    ld_q.push_back(16'hA5F5);
    eng_q.push_back({1'b1, 16'h0040});
    s0 = n_starts;
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 16'h0040;
    wait_ready(1, r2);
    ld_req = 1'b0;
    chk("inval_remiss_start", 32'(n_starts), 32'(s0 + 1));

    // Reset asserted during WAIT.
    eng_lat = 20;
    eng_q.push_back({1'b0, 16'h0500});
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0500;
    wait_start();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    if_req = 1'b0;
    if_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Clean transaction after reset.
    eng_lat = 4;
    if_q.push_back(16'hA3B5);
    eng_q.push_back({1'b0, 16'h0600});
    s0 = n_starts;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0600; rc = cyc;
    wait_ready(0, r1);
    if_req = 1'b0;
    chk("post_rst_start_cyc", 32'(start_cyc), 32'(rc + 1));
    chk("post_rst_ready_cyc", 32'(r1), 32'(done_cyc + 1));
    chk("post_rst_start_count", 32'(n_starts), 32'(s0 + 1));

    repeat (5) @(negedge clk);
    chk("if_q_drained", 32'(if_q.size()), 0);
    chk("ld_q_drained", 32'(ld_q.size()), 0);
    chk("eng_q_drained", 32'(eng_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
